// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Zero-extended payloads are safe here: padding bits do not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        logic p;
        p = ^data;
        if (mode == PARITY_EVEN) return p;
        else if (mode == PARITY_ODD) return ~p;
        else return 1'b0;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write port carrying words into the transmitter FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are dropped.
module uart_sync_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_BITS-1:0]        wdata,
    input  logic                        pop,
    output logic [DATA_BITS-1:0]        rdata,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic                 do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with configurable framing and CTS gating.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        baud_clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               wr,
    input  logic                        cts,
`ifdef UART_TX_BREAK_EN
    input  logic                        break_req,
`endif
    output logic                        tx_out,
    output logic                        tx_busy,
    output logic                        tx_buffer_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam logic [2:0] StIdle   = IDLE;
    localparam logic [2:0] StStart  = START;
    localparam logic [2:0] StData   = DATA;
    localparam logic [2:0] StParity = PARITY;
    localparam logic [2:0] StStop   = STOP;

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] StBreak = BREAK;
    localparam int unsigned FRAME_LEN =
        (1 + DATA_BITS + (HAS_PARITY ? 1 : 0) + STOP_BITS) * CLKS_PER_BIT;
    localparam int unsigned BW = $clog2(FRAME_LEN);
    localparam logic [BW-1:0] BRK_LAST = BW'(FRAME_LEN - 1);
    logic [BW-1:0] brk_q, brk_d;
`endif

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS:0]   shift_q, shift_d;  // {parity, payload}, shifted out LSB first
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 pop, start_frame, last_tick, start_ok;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;

    uart_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (baud_clk),
        .rst   (rst),
        .push  (wr.data_valid),
        .wdata (wr.data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr.data_ready   = !fifo_full;
    assign last_tick       = (cnt_q == LAST_TICK);
    assign start_ok        = !fifo_empty && cts;
    assign tx_out          = tx_q;
    assign tx_busy         = busy_q;
    assign tx_buffer_empty = fifo_empty && !busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_d       = brk_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = StBreak;
                    tx_d    = 1'b0;
                    brk_d   = '0;
                end else
`endif
                if (start_ok) start_frame = 1'b1;
            end
            StStart: begin
                if (last_tick) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q != LAST_BIT) begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_d[0];
                    end else if (HAS_PARITY) begin
                        state_d = StParity;
                        tx_d    = shift_d[0];
                    end else begin
                        state_d = StStop;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (last_tick) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (stop_q != LAST_STOP) begin
                        stop_d = 1'b1;
                    end else if (start_ok) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                tx_d = 1'b0;
                if (brk_q != BRK_LAST) begin
                    brk_d = brk_q + 1'b1;
                end else if (!break_req) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Head word goes straight into the shifter on the edge that drives the start bit.
        if (start_frame) begin
            state_d = StStart;
            cnt_d   = '0;
            tx_d    = 1'b0;
            pop     = 1'b1;
            shift_d = {parity_bit(8'(fifo_rdata), PARITY_MODE), fifo_rdata};
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != StIdle);
`ifdef UART_TX_BREAK_EN
            brk_q   <= brk_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: an 8N1 and a 7O2 instance checked against a frame-level model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int DB   [2] = '{8, 7};
    localparam int PM   [2] = '{0, 2};
    localparam int SB   [2] = '{1, 2};
    localparam int CPB  [2] = '{1, 4};
    localparam int MASK [2] = '{255, 127};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] valid_i = '0;
    logic [1:0] cts_i = 2'b11;
    logic [7:0] din [2];
    logic [1:0] tx_o, busy_o, empty_o, ready_o;
    logic [2:0] cnt_o [2];
`ifdef UART_TX_BREAK_EN
    logic [1:0] brk = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted words and the per-cycle line values of the frame in flight.
    int unsigned mq [2][$];
    bit          lq [2][$];
    int          exp_tx [2], exp_busy [2], exp_ready [2], exp_cnt [2], exp_empty [2];

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) wr0 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) wr1 ();

    assign wr0.data_in    = din[0];
    assign wr0.data_valid = valid_i[0];
    assign ready_o[0]     = wr0.data_ready;
    assign wr1.data_in    = din[1][6:0];
    assign wr1.data_valid = valid_i[1];
    assign ready_o[1]     = wr1.data_ready;

    uart_tx_fifo #(
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)
    ) dut0 (
        .baud_clk        (clk),
        .rst             (rst),
        .wr              (wr0),
        .cts             (cts_i[0]),
`ifdef UART_TX_BREAK_EN
        .break_req       (brk[0]),
`endif
        .tx_out          (tx_o[0]),
        .tx_busy         (busy_o[0]),
        .tx_buffer_empty (empty_o[0]),
        .fifo_count      (cnt_o[0])
    );

    uart_tx_fifo #(
        .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)
    ) dut1 (
        .baud_clk        (clk),
        .rst             (rst),
        .wr              (wr1),
        .cts             (cts_i[1]),
`ifdef UART_TX_BREAK_EN
        .break_req       (brk[1]),
`endif
        .tx_out          (tx_o[1]),
        .tx_busy         (busy_o[1]),
        .tx_buffer_empty (empty_o[1]),
        .fifo_count      (cnt_o[1])
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void build_frame(input int d, input int unsigned w);
        bit b[$];
        int ones;
        ones = 0;
        b.push_back(1'b0);
        for (int i = 0; i < DB[d]; i++) begin
            b.push_back(1'((w >> i) & 1));
            ones += int'((w >> i) & 1);
        end
        if (PM[d] != 0) b.push_back(1'(ones % 2) ^ (PM[d] == 2));
        for (int i = 0; i < SB[d]; i++) b.push_back(1'b1);
        foreach (b[k]) repeat (CPB[d]) lq[d].push_back(b[k]);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            lq[d].delete();
            exp_tx[d] = 1; exp_busy[d] = 0; exp_ready[d] = 1; exp_cnt[d] = 0; exp_empty[d] = 1;
        end
    endfunction

    // Predicts the outputs after the coming edge from the inputs presently applied.
    function automatic void model_step(input int d);
        bit ready;
        ready = (mq[d].size() < DEPTH);
        if (lq[d].size() != 0) begin
            exp_tx[d] = int'(lq[d].pop_front());
            exp_busy[d] = 1;
        end else if (mq[d].size() != 0 && cts_i[d]) begin
            build_frame(d, mq[d].pop_front());
            exp_tx[d] = int'(lq[d].pop_front());
            exp_busy[d] = 1;
        end else begin
            exp_tx[d] = 1;
            exp_busy[d] = 0;
        end
        if (valid_i[d] && ready) mq[d].push_back(din[d] & MASK[d]);
        exp_cnt[d]   = mq[d].size();
        exp_ready[d] = int'(mq[d].size() < DEPTH);
        exp_empty[d] = int'(mq[d].size() == 0 && exp_busy[d] == 0);
    endfunction

    task automatic check_outputs(input int d);
        check($sformatf("d%0d.tx_out", d), tx_o[d], exp_tx[d]);
        check($sformatf("d%0d.tx_busy", d), busy_o[d], exp_busy[d]);
        check($sformatf("d%0d.data_ready", d), ready_o[d], exp_ready[d]);
        check($sformatf("d%0d.fifo_count", d), cnt_o[d], exp_cnt[d]);
        check($sformatf("d%0d.tx_buffer_empty", d), empty_o[d], exp_empty[d]);
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic write_word(input int d, input logic [7:0] w);
        valid_i[d] = 1'b1;
        din[d] = w;
        tick();
        valid_i[d] = 1'b0;
    endtask

    task automatic drain();
        valid_i = '0;
        cts_i = 2'b11;
        for (int i = 0; i < 400; i++) begin
            if (mq[0].size() == 0 && mq[1].size() == 0 && lq[0].size() == 0 &&
                lq[1].size() == 0) break;
            tick();
        end
        tick();
    endtask

    initial begin
        logic [9:0]  pat_a5;
        logic [9:0]  pat_0f;
        logic [10:0] pat_35;
        pat_a5 = 10'b1101001010;
        pat_0f = 10'b1000011110;
        pat_35 = 11'b11101101010;
        din[0] = '0;
        din[1] = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0);
        check_outputs(1);
        rst = 1'b0;
        tick();

        // 8N1 frame of 0xA5, start bit on the edge after the write
        write_word(0, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a5.bit", tx_o[0], pat_a5[i]);
        end
        tick();
        check("a5.busy_end", busy_o[0], 0);
        check("a5.buf_empty", empty_o[0], 1);

        // 7O2 at four clocks per bit: 0x35 has four ones, so the parity bit is 1
        drain();
        write_word(1, 8'h35);
        for (int i = 0; i < 44; i++) begin
            tick();
            check("7o2.bit", tx_o[1], pat_35[i / 4]);
        end
        tick();
        check("7o2.busy_end", busy_o[1], 0);

        // Fill with cts low: only four of six words accepted, then four frames back-to-back
        drain();
        cts_i = 2'b00;
        for (int k = 0; k < 6; k++) write_word(0, 8'(8'h10 + k));
        check("full.count", cnt_o[0], 4);
        check("full.ready", ready_o[0], 0);
        check("full.tx_idle", tx_o[0], 1);
        cts_i = 2'b11;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("b2b.busy", busy_o[0], 1);
        end
        tick();
        check("b2b.busy_end", busy_o[0], 0);
        check("b2b.count", cnt_o[0], 0);

        // cts dropped during data bit 3 of the first of two queued frames
        drain();
        write_word(0, 8'h5A);
        write_word(0, 8'hC3);
        repeat (3) tick();
        cts_i[0] = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("cts.idle_tx", tx_o[0], 1);
            check("cts.idle_busy", busy_o[0], 0);
        end
        cts_i[0] = 1'b1;
        tick();
        check("cts.resume_start", tx_o[0], 0);
        check("cts.resume_busy", busy_o[0], 1);

        // Asynchronous reset in the middle of a data bit
        drain();
        write_word(0, 8'h3C);
        write_word(0, 8'h81);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst.tx_now", tx_o[0], 1);
        check("rst.count_now", cnt_o[0], 0);
        check("rst.busy_now", busy_o[0], 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs(0);
        check_outputs(1);
        write_word(0, 8'h0F);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("0f.bit", tx_o[0], pat_0f[i]);
        end

`ifdef UART_TX_BREAK_EN
        // Break held 30 cycles, then a 2-cycle pulse stretched to one frame time
        drain();
        brk = 2'b11;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            check("brk30.low", tx_o[0], 0);
            check("brk30.busy", busy_o[0], 1);
            if (i == 29) brk = 2'b00;
        end
        @(posedge clk);
        #1;
        check("brk30.release", tx_o[0], 1);
        repeat (50) @(posedge clk);
        #1;
        check("brk30.d1_idle", tx_o[1], 1);
        brk = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) brk = 2'b00;
            check("brkpulse.low", tx_o[0], 0);
        end
        @(posedge clk);
        #1;
        check("brkpulse.release", tx_o[0], 1);
        repeat (50) @(posedge clk);
        #1;
        check("brkpulse.d1_idle", tx_o[1], 1);
        tick();
`endif

        // Random traffic with slowly toggling cts on both instances
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                valid_i[d] = 1'($urandom_range(0, 1));
                din[d] = 8'($urandom);
                if ($urandom_range(0, 19) == 0) cts_i[d] = ~cts_i[d];
            end
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
